// File: rtl/pipe_mem_io_stage_pkg.sv
// Shared constants for the MEM stage: data width, I/O address map and
// output-port indices used by the write strobe.
package pipe_mem_io_stage_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned IO_AW  = 8;
  localparam int unsigned N_OUT  = 3;

  localparam logic [IO_AW-1:0] IO_IN0  = 8'h80;
  localparam logic [IO_AW-1:0] IO_IN1  = 8'h84;
  localparam logic [IO_AW-1:0] IO_OUT0 = 8'hC0;
  localparam logic [IO_AW-1:0] IO_OUT1 = 8'hC4;
  localparam logic [IO_AW-1:0] IO_OUT2 = 8'hC8;

  localparam int unsigned OUT0_IDX = 0;
  localparam int unsigned OUT1_IDX = 1;
  localparam int unsigned OUT2_IDX = 2;

endpackage

// File: rtl/pipe_mem_io_stage_sync2.sv
// Two-flop synchroniser for asynchronous switch inputs; clears to 0 on reset.
module io_sync2 #(
  parameter int unsigned W = 32
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pipe_mem_io_stage.sv
// MEM stage: word-addressed data RAM plus memory-mapped switch inputs and
// LED/seven-segment output registers; load data is combinational from malu.
module pipe_mem_io_stage
  import pipe_mem_io_stage_pkg::*;
#(
  parameter int unsigned RAM_AW = 5,
  parameter int unsigned IO_BIT = 7,
  parameter int unsigned DATA_W = pipe_mem_io_stage_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              mwmem,
  input  logic [DATA_W-1:0] malu,
  input  logic [DATA_W-1:0] mb,
  input  logic [DATA_W-1:0] in_port0,
  input  logic [DATA_W-1:0] in_port1,
  output logic [DATA_W-1:0] mmo,
  output logic [DATA_W-1:0] out_port0,
  output logic [DATA_W-1:0] out_port1,
  output logic [DATA_W-1:0] out_port2,
  output logic [2:0]        io_wr_strobe
);

  localparam int unsigned RAM_WORDS = 1 << RAM_AW;

  logic [DATA_W-1:0] r_ram [RAM_WORDS];
  logic [DATA_W-1:0] r_out [N_OUT];
  logic [N_OUT-1:0]  r_strobe;

  logic              w_is_io;
  logic [RAM_AW-1:0] w_idx;
  logic [IO_AW-1:0]  w_io_addr;
  logic [DATA_W-1:0] w_in0;
  logic [DATA_W-1:0] w_in1;
  logic [N_OUT-1:0]  w_wr_sel;
  logic [DATA_W-1:0] w_mmo;
  logic              w_unused;

  // Upper address bits and byte offset are don't-care; RAM aliases.
  assign w_is_io   = malu[IO_BIT];
  assign w_idx     = malu[RAM_AW+1:2];
  assign w_io_addr = malu[IO_AW-1:0];
  assign w_unused  = ^malu;

  io_sync2 #(.W(DATA_W)) u_sync0 (
    .clock  (clock),
    .resetn (resetn),
    .i_d    (in_port0),
    .o_q    (w_in0)
  );

  io_sync2 #(.W(DATA_W)) u_sync1 (
    .clock  (clock),
    .resetn (resetn),
    .i_d    (in_port1),
    .o_q    (w_in1)
  );

  always_comb begin
    w_wr_sel = '0;
    if (mwmem && w_is_io) begin
      case (w_io_addr)
        IO_OUT0: w_wr_sel[OUT0_IDX] = 1'b1;
        IO_OUT1: w_wr_sel[OUT1_IDX] = 1'b1;
        IO_OUT2: w_wr_sel[OUT2_IDX] = 1'b1;
        default: w_wr_sel = '0;
      endcase
    end
  end

  // Read-before-write RAM: same-cycle load sees the old word.
  always_ff @(posedge clock) begin
    if (mwmem && !w_is_io) begin
      r_ram[w_idx] <= mb;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < int'(N_OUT); k++) begin
        r_out[k] <= '0;
      end
      r_strobe <= '0;
    end else begin
      r_strobe <= w_wr_sel;
      for (int k = 0; k < int'(N_OUT); k++) begin
        if (w_wr_sel[k]) begin
          r_out[k] <= mb;
        end
      end
    end
  end

  always_comb begin
    w_mmo = '0;
    if (!w_is_io) begin
      w_mmo = r_ram[w_idx];
    end else begin
      case (w_io_addr)
        IO_IN0:  w_mmo = w_in0;
        IO_IN1:  w_mmo = w_in1;
        IO_OUT0: w_mmo = r_out[OUT0_IDX];
        IO_OUT1: w_mmo = r_out[OUT1_IDX];
        IO_OUT2: w_mmo = r_out[OUT2_IDX];
        default: w_mmo = '0;
      endcase
    end
  end

  assign mmo          = w_mmo;
  assign out_port0    = r_out[OUT0_IDX];
  assign out_port1    = r_out[OUT1_IDX];
  assign out_port2    = r_out[OUT2_IDX];
  assign io_wr_strobe = r_strobe;

endmodule

// File: tb/tb_pipe_mem_io_stage.sv
// Self-checking bench for pipe_mem_io_stage: expected load/strobe values are
// queued when stimulus is driven and popped when the DUT output is observed.
module tb_pipe_mem_io_stage;

  logic        clock = 1'b0;
  logic        resetn;
  logic        mwmem;
  logic [31:0] malu;
  logic [31:0] mb;
  logic [31:0] in_port0;
  logic [31:0] in_port1;
  logic [31:0] mmo;
  logic [31:0] out_port0;
  logic [31:0] out_port1;
  logic [31:0] out_port2;
  logic [2:0]  io_wr_strobe;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [31:0] exp_q [$];
  logic [31:0] exp;
  logic [31:0] m_out0, m_out1, m_out2;

  pipe_mem_io_stage dut (
    .clock        (clock),
    .resetn       (resetn),
    .mwmem        (mwmem),
    .malu         (malu),
    .mb           (mb),
    .in_port0     (in_port0),
    .in_port1     (in_port1),
    .mmo          (mmo),
    .out_port0    (out_port0),
    .out_port1    (out_port1),
    .out_port2    (out_port2),
    .io_wr_strobe (io_wr_strobe)
  );

  always #5 clock = ~clock;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; mwmem = 1'b1; malu = 32'hC0; mb = 32'hFFFF;
    step(); step();
    n_checks++; if (out_port0 !== 32'h0) begin n_fail++; $display("FAIL reset_out0 got=%h exp=0", out_port0); end
    n_checks++; if (out_port1 !== 32'h0) begin n_fail++; $display("FAIL reset_out1 got=%h exp=0", out_port1); end
    n_checks++; if (out_port2 !== 32'h0) begin n_fail++; $display("FAIL reset_out2 got=%h exp=0", out_port2); end
    n_checks++; if (io_wr_strobe !== 3'b000) begin n_fail++; $display("FAIL reset_strobe got=%b exp=000", io_wr_strobe); end
    resetn = 1'b1; mwmem = 1'b1; malu = 32'hC0; mb = 32'h5A;
    m_out0 = 32'h5A; m_out1 = 32'h0; m_out2 = 32'h0;
    exp_q.push_back(32'h5A); exp_q.push_back(32'h1); exp_q.push_back(32'h0);
    step();
    mwmem = 1'b0;
    exp = exp_q.pop_front();
    n_checks++; if (out_port0 !== exp) begin n_fail++; $display("FAIL first_store_out0 got=%h exp=%h", out_port0, exp); end
    exp = exp_q.pop_front();
    n_checks++; if (io_wr_strobe !== exp[2:0]) begin n_fail++; $display("FAIL first_store_strobe got=%b exp=%b", io_wr_strobe, exp[2:0]); end
    step();
    exp = exp_q.pop_front();
    n_checks++; if (io_wr_strobe !== exp[2:0]) begin n_fail++; $display("FAIL strobe_one_cycle got=%b exp=%b", io_wr_strobe, exp[2:0]); end
  endtask

  task automatic test_ram();
    logic [31:0] addrs [4];
    addrs = '{32'h04, 32'h08, 32'h104, 32'h4006};
    mwmem = 1'b1; malu = 32'h04; mb = 32'hDEADBEEF; step();
    malu = 32'h08; mb = 32'h12345678; step();
    mwmem = 1'b0;
    exp_q.push_back(32'hDEADBEEF); exp_q.push_back(32'h12345678);
    exp_q.push_back(32'hDEADBEEF); exp_q.push_back(32'hDEADBEEF);
    for (int i = 0; i < 4; i++) begin
      malu = addrs[i]; #1;
      exp = exp_q.pop_front();
      n_checks++; if (mmo !== exp) begin n_fail++; $display("FAIL ram_load addr=%h got=%h exp=%h", addrs[i], mmo, exp); end
    end
    step();
  endtask

  task automatic test_rdw();
    mwmem = 1'b1; malu = 32'h10; mb = 32'h1; step();
    mb = 32'h2; #1;
    exp_q.push_back(32'h1); exp_q.push_back(32'h2);
    exp = exp_q.pop_front();
    n_checks++; if (mmo !== exp) begin n_fail++; $display("FAIL rdw_same_cycle got=%h exp=%h", mmo, exp); end
    step();
    mwmem = 1'b0; #1;
    exp = exp_q.pop_front();
    n_checks++; if (mmo !== exp) begin n_fail++; $display("FAIL rdw_next_cycle got=%h exp=%h", mmo, exp); end
  endtask

  task automatic test_sync();
    mwmem = 1'b0; malu = 32'h84;
    in_port1 = 32'hA5;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    exp_q.push_back(32'hA5); exp_q.push_back(32'hA5);
    for (int c = 0; c < 4; c++) begin
      #1;
      exp = exp_q.pop_front();
      n_checks++; if (mmo !== exp) begin n_fail++; $display("FAIL sync_in1 cycle=N+%0d got=%h exp=%h", c, mmo, exp); end
      step();
    end
    in_port0 = 32'h3C; malu = 32'h80;
    step(); step();
    exp_q.push_back(32'h3C);
    exp = exp_q.pop_front();
    n_checks++; if (mmo !== exp) begin n_fail++; $display("FAIL sync_in0 got=%h exp=%h", mmo, exp); end
  endtask

  task automatic test_unmapped();
    logic [31:0] addrs [2];
    addrs = '{32'h80, 32'hD0};
    for (int i = 0; i < 2; i++) begin
      mwmem = 1'b1; malu = addrs[i]; mb = 32'h77; step();
      mwmem = 1'b0;
      n_checks++; if (io_wr_strobe !== 3'b000) begin n_fail++; $display("FAIL unmapped_strobe addr=%h got=%b exp=000", addrs[i], io_wr_strobe); end
      n_checks++;
      if (out_port0 !== m_out0 || out_port1 !== m_out1 || out_port2 !== m_out2) begin
        n_fail++;
        $display("FAIL unmapped_outs addr=%h got=%h/%h/%h exp=%h/%h/%h", addrs[i],
                 out_port0, out_port1, out_port2, m_out0, m_out1, m_out2);
      end
    end
    malu = 32'h80; #1;
    exp_q.push_back(32'h3C);
    exp = exp_q.pop_front();
    n_checks++; if (mmo !== exp) begin n_fail++; $display("FAIL in0_readonly got=%h exp=%h", mmo, exp); end
    malu = 32'hD0; #1;
    exp_q.push_back(32'h0);
    exp = exp_q.pop_front();
    n_checks++; if (mmo !== exp) begin n_fail++; $display("FAIL unmapped_load got=%h exp=%h", mmo, exp); end
    step();
    mwmem = 1'b1; malu = 32'hC8; mb = 32'h3F; m_out2 = 32'h3F;
    exp_q.push_back(32'h4);
    step();
    mwmem = 1'b0;
    exp = exp_q.pop_front();
    n_checks++; if (io_wr_strobe !== exp[2:0]) begin n_fail++; $display("FAIL out2_strobe got=%b exp=%b", io_wr_strobe, exp[2:0]); end
    n_checks++; if (out_port2 !== m_out2) begin n_fail++; $display("FAIL out2_pin got=%h exp=%h", out_port2, m_out2); end
    #1;
    exp_q.push_back(32'h3F);
    exp = exp_q.pop_front();
    n_checks++; if (mmo !== exp) begin n_fail++; $display("FAIL out2_readback got=%h exp=%h", mmo, exp); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3];
    vals = '{32'h11, 32'h22, 32'h99};
    mwmem = 1'b1; malu = 32'hC4;
    for (int i = 0; i < 3; i++) begin
      mb = vals[i]; m_out1 = vals[i];
      exp_q.push_back(32'h2);
      step();
      exp = exp_q.pop_front();
      n_checks++; if (io_wr_strobe !== exp[2:0]) begin n_fail++; $display("FAIL b2b_strobe idx=%0d got=%b exp=%b", i, io_wr_strobe, exp[2:0]); end
      n_checks++; if (out_port1 !== m_out1) begin n_fail++; $display("FAIL b2b_out1 idx=%0d got=%h exp=%h", i, out_port1, m_out1); end
    end
    mwmem = 1'b0;
    exp_q.push_back(32'h0);
    step();
    exp = exp_q.pop_front();
    n_checks++; if (io_wr_strobe !== exp[2:0]) begin n_fail++; $display("FAIL b2b_strobe_end got=%b exp=%b", io_wr_strobe, exp[2:0]); end
  endtask

  task automatic test_async_reset();
    n_checks++; if (out_port1 !== 32'h99) begin n_fail++; $display("FAIL pre_reset_out1 got=%h exp=00000099", out_port1); end
    malu = 32'h84;
    #2 resetn = 1'b0;
    #1;
    n_checks++; if (out_port1 !== 32'h0) begin n_fail++; $display("FAIL async_reset_out1 got=%h exp=0", out_port1); end
    n_checks++; if (out_port0 !== 32'h0) begin n_fail++; $display("FAIL async_reset_out0 got=%h exp=0", out_port0); end
    exp_q.push_back(32'h0);
    exp = exp_q.pop_front();
    n_checks++; if (mmo !== exp) begin n_fail++; $display("FAIL async_reset_sync got=%h exp=%h", mmo, exp); end
    #1 resetn = 1'b1;
    mwmem = 1'b1; malu = 32'hC0; mb = 32'hA1;
    step();
    mwmem = 1'b0;
    n_checks++; if (out_port0 !== 32'hA1) begin n_fail++; $display("FAIL post_reset_store got=%h exp=000000a1", out_port0); end
    malu = 32'h08; #1;
    exp_q.push_back(32'h12345678);
    exp = exp_q.pop_front();
    n_checks++; if (mmo !== exp) begin n_fail++; $display("FAIL ram_kept_over_reset got=%h exp=%h", mmo, exp); end
  endtask

  initial begin
    resetn = 1'b0; mwmem = 1'b0; malu = '0; mb = '0;
    in_port0 = '0; in_port1 = '0;
    m_out0 = '0; m_out1 = '0; m_out2 = '0;
    #1;
    test_reset();
    test_ram();
    test_rdw();
    test_sync();
    test_unmapped();
    test_back_to_back();
    test_async_reset();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
